// File: rtl/input_debounce.sv
// Pad-input conditioning: optional inversion, 2-flop synchroniser and a
// per-channel stability counter, with registered rise/fall/chg pulses.

module input_debounce_lane #(
  parameter int   CW      = 1,
  parameter int   LAST    = 0,
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk1_50,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept
);
  localparam logic [CW-1:0] LAST_C = CW'(LAST);

  (* ASYNC_REG = "TRUE" *) logic s1;
  (* ASYNC_REG = "TRUE" *) logic s2;
  logic [CW-1:0] cnt;

  // Change is taken on this edge; used by the parent to register chg in step.
  assign accept = (s2 != level) && (cnt == LAST_C);

  always_ff @(posedge clk1_50 or posedge rst) begin
    if (rst) begin
      s1    <= RST_BIT;
      s2    <= RST_BIT;
      level <= RST_BIT;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST_C) begin
        level <= s2;
        cnt   <= '0;
        rise  <= s2;
        fall  <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module input_debounce #(
  parameter int               WIDTH     = 12,
  parameter int               DB_CYCLES = 250000,
  parameter logic [WIDTH-1:0] INV_MASK  = 12'h003,
  parameter logic [WIDTH-1:0] RST_VAL   = 12'h000
) (
  input  logic             clk1_50,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             chg
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [WIDTH-1:0] raw_inv;
  logic [WIDTH-1:0] accept;

  assign raw_inv = raw ^ INV_MASK;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    input_debounce_lane #(
      .CW      (CW),
      .LAST    (DB_CYCLES - 1),
      .RST_BIT (RST_VAL[g])
    ) u_lane (
      .clk1_50 (clk1_50),
      .rst     (rst),
      .din     (raw_inv[g]),
      .level   (level[g]),
      .rise    (rise[g]),
      .fall    (fall[g]),
      .accept  (accept[g])
    );
  end

  always_ff @(posedge clk1_50 or posedge rst) begin
    if (rst) chg <= 1'b0;
    else     chg <= |accept;
  end
endmodule

// File: tb/tb_input_debounce.sv
// Directed bench: DB_CYCLES=8 main instance plus a DB_CYCLES=1 instance.

module tb_input_debounce;
  logic        clk1_50 = 1'b0;
  logic        rst;
  logic [11:0] raw;
  logic [11:0] level, rise, fall;
  logic        chg;
  logic [11:0] level1, rise1, fall1;
  logic        chg1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk1_50 = ~clk1_50;

  input_debounce #(.WIDTH(12), .DB_CYCLES(8), .INV_MASK(12'h003), .RST_VAL(12'h000)) dut (
    .clk1_50 (clk1_50), .rst (rst), .raw (raw),
    .level (level), .rise (rise), .fall (fall), .chg (chg)
  );

  input_debounce #(.WIDTH(12), .DB_CYCLES(1), .INV_MASK(12'h003), .RST_VAL(12'h000)) dut1 (
    .clk1_50 (clk1_50), .rst (rst), .raw (raw),
    .level (level1), .rise (rise1), .fall (fall1), .chg (chg1)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk1_50);
    #1;
  endtask

  task automatic settle(input logic [11:0] v);
    raw = v;
    repeat (12) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    raw = 12'hFFF;
    repeat (3) step();
    n_checks++;
    if (level !== 12'h000) begin n_fail++; $display("FAIL reset_level: got %h want %h", level, 12'h000); end
    n_checks++;
    if ({rise, fall, chg} !== 25'h0) begin n_fail++; $display("FAIL reset_pulses: got rise=%h fall=%h chg=%b want 0", rise, fall, chg); end
    rst = 1'b0;
    repeat (9) step();
    n_checks++;
    if (level !== 12'h000) begin n_fail++; $display("FAIL reset_early: got %h want %h at edge 9", level, 12'h000); end
    step();
    n_checks++;
    if (level !== 12'hFFC || rise !== 12'hFFC || chg !== 1'b1 || fall !== 12'h000) begin
      n_fail++; $display("FAIL reset_accept: got level=%h rise=%h fall=%h chg=%b want FFC/FFC/000/1", level, rise, fall, chg);
    end
    step();
    n_checks++;
    if (level !== 12'hFFC || rise !== 12'h000 || chg !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulse_width: got level=%h rise=%h chg=%b want FFC/000/0", level, rise, chg);
    end
    settle(12'h003);
    n_checks++;
    if (level !== 12'h000) begin n_fail++; $display("FAIL idle_level: got %h want %h", level, 12'h000); end
  endtask

  task automatic test_press();
    raw = 12'h002;
    for (int i = 1; i <= 11; i++) begin
      step();
      n_checks++;
      if (rise !== ((i == 10) ? 12'h001 : 12'h000) || fall !== 12'h000 || chg !== (i == 10)) begin
        n_fail++; $display("FAIL press_edge%0d: got rise=%h fall=%h chg=%b", i, rise, fall, chg);
      end
    end
    n_checks++;
    if (level !== 12'h001) begin n_fail++; $display("FAIL press_level: got %h want %h", level, 12'h001); end
    settle(12'h003);
  endtask

  task automatic test_bounce();
    logic [11:0] v;
    v = 12'h003;
    for (int c = 0; c < 40; c++) begin
      v[5] = ((c % 5) < 3);
      raw = v;
      step();
      n_checks++;
      if (chg !== 1'b0 || level[5] !== 1'b0) begin
        n_fail++; $display("FAIL bounce_cycle%0d: got chg=%b level5=%b want 0/0", c, chg, level[5]);
      end
    end
    v[5] = 1'b1;
    raw = v;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_checks++;
      if (rise !== ((i == 10) ? 12'h020 : 12'h000)) begin
        n_fail++; $display("FAIL bounce_settle%0d: got rise=%h", i, rise);
      end
    end
    settle(12'h003);
  endtask

  task automatic test_glitch();
    raw = 12'h00B;
    repeat (7) step();
    raw = 12'h003;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (chg !== 1'b0 || rise !== 12'h000 || fall !== 12'h000 || level[3] !== 1'b0) begin
        n_fail++; $display("FAIL glitch_cycle%0d: got level=%h rise=%h fall=%h chg=%b", i, level, rise, fall, chg);
      end
    end
  endtask

  task automatic test_simultaneous();
    raw = 12'hA07;
    repeat (9) step();
    n_checks++;
    if (level !== 12'h000) begin n_fail++; $display("FAIL simul_early: got %h want %h", level, 12'h000); end
    step();
    n_checks++;
    if (level !== 12'hA04 || rise !== 12'hA04 || chg !== 1'b1) begin
      n_fail++; $display("FAIL simul_rise: got level=%h rise=%h chg=%b want A04/A04/1", level, rise, chg);
    end
    step();
    n_checks++;
    if (chg !== 1'b0 || rise !== 12'h000) begin n_fail++; $display("FAIL simul_width: got chg=%b rise=%h want 0", chg, rise); end
    raw = 12'h003;
    repeat (10) step();
    n_checks++;
    if (level !== 12'h000 || fall !== 12'hA04 || chg !== 1'b1) begin
      n_fail++; $display("FAIL simul_fall: got level=%h fall=%h chg=%b want 000/A04/1", level, fall, chg);
    end
    step();
    n_checks++;
    if (chg !== 1'b0) begin n_fail++; $display("FAIL simul_fall_width: got chg=%b want 0", chg); end
    repeat (2) step();
  endtask

  task automatic test_mid_reset();
    raw = 12'h013;
    repeat (7) step();
    rst = 1'b1;
    step();
    n_checks++;
    if (level !== 12'h000 || chg !== 1'b0) begin n_fail++; $display("FAIL midrst_hold: got level=%h chg=%b", level, chg); end
    rst = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      step();
      n_checks++;
      if (rise !== ((i == 10) ? 12'h010 : 12'h000)) begin
        n_fail++; $display("FAIL midrst_edge%0d: got rise=%h", i, rise);
      end
    end
    settle(12'h003);
  endtask

  task automatic test_db1();
    raw = 12'h043;
    repeat (2) step();
    n_checks++;
    if (level1 !== 12'h000 || rise1 !== 12'h000) begin n_fail++; $display("FAIL db1_early: got level=%h rise=%h", level1, rise1); end
    step();
    n_checks++;
    if (level1 !== 12'h040 || rise1 !== 12'h040 || chg1 !== 1'b1) begin
      n_fail++; $display("FAIL db1_accept: got level=%h rise=%h chg=%b want 040/040/1", level1, rise1, chg1);
    end
    step();
    n_checks++;
    if (rise1 !== 12'h000 || chg1 !== 1'b0) begin n_fail++; $display("FAIL db1_width: got rise=%h chg=%b", rise1, chg1); end
    settle(12'h003);
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_mid_reset();
    test_db1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
